// File: rtl/reg_file_sequencer_if.sv
// Instruction/control bundle between the front panel and the sequencer.
// Carries the execute request, instruction word and every datapath control line.
// master drives Exec/INSTR; slave (the sequencer) drives the control outputs.
interface reg_file_sequencer_if;
    logic       Exec;
    logic [9:0] INSTR;
    logic       ENW;
    logic [1:0] WRA;
    logic       ENR0;
    logic [1:0] RDA0;
    logic       ENR1;
    logic [1:0] RDA1;
    logic       Extrn;
    logic       Ain;
    logic       Gin;
    logic       Gout;
    logic [3:0] ALUcont;
    logic       Done;
    logic [1:0] Tstep;

    modport master (
        output Exec, INSTR,
        input  ENW, WRA, ENR0, RDA0, ENR1, RDA1, Extrn, Ain, Gin, Gout,
               ALUcont, Done, Tstep
    );

    modport slave (
        input  Exec, INSTR,
        output ENW, WRA, ENR0, RDA0, ENR1, RDA1, Extrn, Ain, Gin, Gout,
               ALUcont, Done, Tstep
    );
endinterface

// File: rtl/reg_file_sequencer.sv
// Multi-cycle instruction sequencer driving register file, bus, A-latch, ALU and G.
// Latency: LOAD/COPY/NOP finish in 1 cycle after the Exec edge, ALU ops in 3.
// No backpressure: Exec rising edges outside the idle state are simply ignored.
module reg_file_sequencer #(
    parameter int OPW = 4
) (
    input  logic                 CLKb,
    input  logic                 Clear,
    reg_file_sequencer_if.slave  bus
);

    typedef enum logic [1:0] {
        T0 = 2'd0,
        T1 = 2'd1,
        T2 = 2'd2,
        T3 = 2'd3
    } state_t;

    localparam logic [OPW-1:0] OP_LOAD = 4'd0;
    localparam logic [OPW-1:0] OP_COPY = 4'd1;
    localparam logic [OPW-1:0] OP_INV  = 4'd4;
    localparam logic [OPW-1:0] OP_NEG  = 4'd5;
    localparam logic [OPW-1:0] OP_LAST = 4'd11;

    state_t         state_q, state_d;
    logic [9:0]     ir_q, ir_d;
    logic           exec_q;

    logic [OPW-1:0] opcode;
    logic [1:0]     rx;
    logic [1:0]     ry;
    logic           is_alu;
    logic           is_binary;
    logic           unused_ir_bits;

    assign opcode    = ir_q[9:6];
    assign rx        = ir_q[5:4];
    assign ry        = ir_q[3:2];
    // Opcodes 2..11 go through the ALU; INV/NEG take no B operand.
    assign is_alu    = (opcode >= 4'd2) && (opcode <= OP_LAST);
    assign is_binary = is_alu && (opcode != OP_INV) && (opcode != OP_NEG);
    // Low instruction bits are latched with the word but carry no meaning.
    assign unused_ir_bits = ^ir_q[1:0];

    // State, instruction and Exec history registers; Exec history resets high
    // so a level held through Clear cannot masquerade as a fresh edge.
    always_ff @(posedge CLKb or posedge Clear) begin
        if (Clear) begin
            state_q <= T0;
            ir_q    <= '0;
            exec_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            exec_q  <= bus.Exec;
        end
    end

    // Next-state: start only on an Exec rising edge while idle.
    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        case (state_q)
            T0: begin
                if (bus.Exec && !exec_q) begin
                    ir_d    = bus.INSTR;
                    state_d = T1;
                end
            end
            T1:      state_d = is_alu ? T2 : T0;
            T2:      state_d = T3;
            T3:      state_d = T0;
            default: state_d = T0;
        endcase
    end

    // Moore output decode from state and latched instruction.
    always_comb begin
        bus.ENW     = 1'b0;
        bus.WRA     = 2'd0;
        bus.ENR0    = 1'b0;
        bus.RDA0    = 2'd0;
        bus.ENR1    = 1'b0;
        bus.RDA1    = 2'd0;
        bus.Extrn   = 1'b0;
        bus.Ain     = 1'b0;
        bus.Gin     = 1'b0;
        bus.Gout    = 1'b0;
        bus.ALUcont = 4'd0;
        bus.Done    = 1'b0;
        bus.Tstep   = state_q;
        case (state_q)
            T1: begin
                if (opcode == OP_LOAD) begin
                    bus.Extrn = 1'b1;
                    bus.ENW   = 1'b1;
                    bus.WRA   = rx;
                    bus.Done  = 1'b1;
                end else if (opcode == OP_COPY) begin
                    bus.ENR0  = 1'b1;
                    bus.RDA0  = ry;
                    bus.ENW   = 1'b1;
                    bus.WRA   = rx;
                    bus.Done  = 1'b1;
                end else if (is_alu) begin
                    bus.ENR0  = 1'b1;
                    bus.RDA0  = rx;
                    bus.Ain   = 1'b1;
                end else begin
                    bus.Done  = 1'b1;
                end
            end
            T2: begin
                bus.ALUcont = opcode;
                bus.Gin     = 1'b1;
                if (is_binary) begin
                    bus.ENR1 = 1'b1;
                    bus.RDA1 = ry;
                end
            end
            T3: begin
                bus.Gout = 1'b1;
                bus.ENW  = 1'b1;
                bus.WRA  = rx;
                bus.Done = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_reg_file_sequencer.sv
// Scoreboard bench: stimulus pushes per-cycle expected control vectors,
// a negedge monitor pops and compares them against the sequencer outputs.
module tb_reg_file_sequencer;

    typedef struct packed {
        logic       ENW;
        logic [1:0] WRA;
        logic       ENR0;
        logic [1:0] RDA0;
        logic       ENR1;
        logic [1:0] RDA1;
        logic       Extrn;
        logic       Ain;
        logic       Gin;
        logic       Gout;
        logic [3:0] ALUcont;
        logic       Done;
        logic [1:0] Tstep;
    } obs_t;

    logic CLKb;
    logic Clear;

    reg_file_sequencer_if bus ();

    reg_file_sequencer #(.OPW(4)) dut (
        .CLKb  (CLKb),
        .Clear (Clear),
        .bus   (bus)
    );

    initial begin
        CLKb = 1'b0;
        forever #5 CLKb = ~CLKb;
    end

    int   checks   = 0;
    int   failures = 0;
    obs_t exp_q[$];
    int   busy      = 0;
    logic exec_prev = 1'b1;

    function automatic obs_t sample();
        obs_t o;
        o.ENW     = bus.ENW;
        o.WRA     = bus.WRA;
        o.ENR0    = bus.ENR0;
        o.RDA0    = bus.RDA0;
        o.ENR1    = bus.ENR1;
        o.RDA1    = bus.RDA1;
        o.Extrn   = bus.Extrn;
        o.Ain     = bus.Ain;
        o.Gin     = bus.Gin;
        o.Gout    = bus.Gout;
        o.ALUcont = bus.ALUcont;
        o.Done    = bus.Done;
        o.Tstep   = bus.Tstep;
        return o;
    endfunction

    task automatic check_obs(input string name, input obs_t act, input obs_t exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0t got=%b exp=%b", name, $time, act, exp);
        end
    endtask

    task automatic check_bit(input string name, input logic ok);
        checks++;
        if (ok !== 1'b1) begin
            failures++;
            $display("FAIL %s t=%0t rule violated (got 0, need 1)", name, $time);
        end
    endtask

    // Reference model: expected control pattern per cycle for one instruction.
    function automatic void push_instr(input logic [9:0] ins);
        obs_t e;
        logic [3:0] op;
        logic [1:0] rx;
        logic [1:0] ry;
        op = ins[9:6];
        rx = ins[5:4];
        ry = ins[3:2];
        e = '0;
        e.Tstep = 2'd1;
        if (op == 4'd0) begin
            e.Extrn = 1'b1; e.ENW = 1'b1; e.WRA = rx; e.Done = 1'b1;
            exp_q.push_back(e);
            busy = 1;
        end else if (op == 4'd1) begin
            e.ENR0 = 1'b1; e.RDA0 = ry; e.ENW = 1'b1; e.WRA = rx; e.Done = 1'b1;
            exp_q.push_back(e);
            busy = 1;
        end else if (op >= 4'd12) begin
            e.Done = 1'b1;
            exp_q.push_back(e);
            busy = 1;
        end else begin
            e.ENR0 = 1'b1; e.RDA0 = rx; e.Ain = 1'b1;
            exp_q.push_back(e);
            e = '0;
            e.Tstep = 2'd2; e.ALUcont = op; e.Gin = 1'b1;
            if (op != 4'd4 && op != 4'd5) begin
                e.ENR1 = 1'b1; e.RDA1 = ry;
            end
            exp_q.push_back(e);
            e = '0;
            e.Tstep = 2'd3; e.Gout = 1'b1; e.ENW = 1'b1; e.WRA = rx; e.Done = 1'b1;
            exp_q.push_back(e);
            busy = 3;
        end
    endfunction

    // Apply inputs for one cycle, then let the model observe the rising edge.
    task automatic step(input logic e, input logic [9:0] ins);
        bus.Exec  = e;
        bus.INSTR = ins;
        @(posedge CLKb);
        if (!Clear) begin
            if (busy > 0)
                busy--;
            else if (bus.Exec && !exec_prev)
                push_instr(bus.INSTR);
            exec_prev = bus.Exec;
        end
        #2;
    endtask

    // Asynchronous clear held across n edges; outputs must drop immediately.
    task automatic do_clear(input string name, input int n);
        Clear = 1'b1;
        #1;
        check_obs(name, sample(), obs_t'(0));
        exp_q.delete();
        busy      = 0;
        exec_prev = 1'b1;
        repeat (n) @(posedge CLKb);
        #2;
        Clear = 1'b0;
    endtask

    // Monitor: every cycle, DUT outputs must match the next expected vector,
    // or be all-zero idle when nothing is pending.
    always @(negedge CLKb) begin
        obs_t act;
        obs_t exp;
        act = sample();
        if (exp_q.size() > 0) exp = exp_q.pop_front();
        else                  exp = '0;
        check_obs("cycle", act, exp);
        check_bit("single_bus_driver", $countones({act.ENR0, act.Extrn, act.Gout}) <= 1);
        check_bit("enw_only_with_done", !act.ENW || act.Done);
    end

    initial begin
        Clear     = 1'b0;
        bus.Exec  = 1'b1;
        bus.INSTR = '0;
        #1;
        // Reset with Exec high; Exec still high after release must not start.
        do_clear("reset_outputs", 2);
        repeat (3) step(1'b1, 10'b0000_10_00_00);
        step(1'b0, '0);
        // LOAD R2
        step(1'b1, 10'b0000_10_00_00);
        step(1'b0, '0);
        step(1'b0, '0);
        // ADD R1,R3 with INSTR scribbled after the start edge
        step(1'b1, 10'b0010_01_11_00);
        repeat (4) step(1'b0, 10'($urandom));
        // INV R2
        step(1'b1, 10'b0100_10_01_00);
        repeat (4) step(1'b0, '0);
        // COPY R3 <- R0
        step(1'b1, 10'b0001_11_00_00);
        repeat (2) step(1'b0, '0);
        // Reserved opcode, then Exec held high: no second start
        step(1'b1, 10'b1110_10_11_01);
        repeat (10) step(1'b1, 10'($urandom));
        repeat (2) step(1'b0, '0);
        // SUB aborted in T2
        step(1'b1, 10'b0011_01_10_00);
        step(1'b0, '0);
        do_clear("abort_in_t2", 1);
        repeat (3) step(1'b0, '0);
        // Randomized traffic with occasional clears
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 59) == 0)
                do_clear("random_clear", int'($urandom_range(1, 2)));
            else
                step(1'(($urandom_range(0, 2) == 0) ? 0 : ($urandom % 2)), 10'($urandom));
        end
        repeat (5) step(1'b0, '0);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain pending=%0d need=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
